slave_port: RTL and testbench
=============================

SLAVE_PORT -- requirements
Module: slave_port

Interface
REQ-001 Parameter ADDR_LEN, default 12, memory address width in bits.
REQ-002 Parameter DATA_LEN, default 8, data word width in bits.
REQ-003 Parameter BURST_LEN, default 12, burst-count width in bits; BURST_LEN <= ADDR_LEN.
REQ-004 Ports are listed below as name, direction, width, meaning.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 s_rx_address  in  1  serial address bit, LSB first.
REQ-008 s_rx_burst  in  1  serial burst-count bit, LSB first, sampled alongside the address.
REQ-009 s_rx_data  in  1  serial write-data bit, LSB first.
REQ-010 s_write_en / s_read_en  in  1 each  transaction type from the master.
REQ-011 s_master_valid  in  1  master drives valid serial bits this cycle.
REQ-012 s_master_ready  in  1  master accepts s_tx_data this cycle.
REQ-013 s_slave_delay  in  6  number of read wait cycles.
REQ-014 s_slave_ready  out  1  slave able to accept serial bits.
REQ-015 s_slave_valid  out  1  s_tx_data is valid.
REQ-016 s_tx_data  out  1  serial read-data bit, LSB first.
REQ-017 s_split_en  out  1  slave requests a bus split during a read wait.
REQ-018 mem_addr  out  ADDR_LEN  local memory address.
REQ-019 mem_wdata  out  DATA_LEN  local write data.
REQ-020 mem_we / mem_re  out  1 each  single-cycle memory strobes.
REQ-021 mem_rdata  in  DATA_LEN  memory read data, valid one cycle after mem_re.

Function
REQ-022 FSM states: IDLE, ADDR, WDATA, WRITE, RDELAY, RFETCH, RDATA, DONE.
REQ-023 IDLE: s_slave_ready=1; s_master_valid=1 with exactly one of s_write_en/s_read_en moves to ADDR and samples bit 0 of address/burst the same cycle.
REQ-024 IDLE with both enables high, or neither: no transition, request ignored.
REQ-025 ADDR: one address bit per cycle while s_master_valid=1, ADDR_LEN bits total; burst bits captured on the first BURST_LEN of those cycles; s_master_valid=0 stalls without loss.
REQ-026 Latched write/read type is fixed for the whole transaction; enable changes after IDLE are ignored.
REQ-027 Beat count = burst value, with burst value 0 treated as 1 beat.
REQ-028 Beat k address = base + k modulo 2^ADDR_LEN; 0xFFF + 1 wraps to 0x000.
REQ-029 After the last address bit: write goes to WDATA, read goes to RDELAY.
REQ-030 WDATA: s_slave_ready=1; one data bit shifted per s_master_valid cycle; after DATA_LEN bits go to WRITE.
REQ-031 WRITE: lasts exactly 1 cycle with mem_we=1, mem_addr = beat address, mem_wdata = assembled word, s_slave_ready=0; then next beat goes to WDATA, last beat goes to DONE.
REQ-032 RDELAY: counts s_slave_delay cycles (0 means skip immediately); s_split_en=1 throughout when s_slave_delay != 0, else 0; then go to RFETCH.
REQ-033 RFETCH: mem_re=1 for 1 cycle with mem_addr = beat address; mem_rdata is latched into the shift register on the next cycle, which is the first cycle of RDATA.
REQ-034 RDATA: s_slave_valid=1, s_tx_data = current LSB; the shift advances only on cycles with s_master_ready=1; after DATA_LEN accepted bits, next beat goes to RDELAY and last beat goes to DONE.
REQ-035 s_slave_valid and s_split_en are never asserted together.
REQ-036 DONE: 1 cycle with all strobes and valids 0, then IDLE.
REQ-037 Read latency from last address bit to first s_slave_valid = s_slave_delay + 2 cycles.
REQ-038 mem_we and mem_re are never asserted together, and each is asserted at most one cycle per beat.

Reset
REQ-039 reset=1 forces IDLE asynchronously, clears shift registers and counters, and sets s_slave_ready=1 and all other outputs to 0.
REQ-040 reset mid-transaction: no further mem_we/mem_re; the partial word is discarded.

Verification
REQ-041 Single write: address 0x005, burst 0, data 0xA5 -> exactly one mem_we, mem_addr=0x005, mem_wdata=0xA5, DONE then IDLE.
REQ-042 Burst read: address 0x010, burst 3, delay 0, mem returns 0x11/0x22/0x33 -> serial output 0x11, 0x22, 0x33 LSB first; mem_addr 0x010, 0x011, 0x012.
REQ-043 Wrap and stall: address 0xFFF, burst 2 write, s_master_valid low 3 cycles mid-word -> writes at 0xFFF then 0x000, data intact.
REQ-044 Read with delay 5 and s_master_ready toggling -> s_split_en high 5 cycles, first s_slave_valid 7 cycles after the last address bit, no bit skipped or repeated.
REQ-045 Both s_write_en and s_read_en high in IDLE -> stays IDLE, no strobes.
REQ-046 reset asserted during WDATA bit 4 -> immediate IDLE outputs, no mem_we; the following write completes normally.

Source files
------------

// File: rtl/slave_port.sv
// Serial-to-parallel slave port: shifts in address/burst/write data LSB first,
// drives single-cycle memory strobes and shifts read data back out per beat.
//
// state  | meaning
// IDLE   | waiting for a valid request with exactly one of write/read enables
// ADDR   | shifting in address bits (burst bits on the first BURST_LEN of them)
// WDATA  | shifting in one write data word
// WRITE  | one-cycle mem_we for the current beat
// RDELAY | read wait cycles, bus split requested
// RFETCH | one-cycle mem_re for the current beat
// RDATA  | shifting out the fetched word as master accepts bits
// DONE   | one quiet cycle before returning to IDLE
`timescale 1ns/1ps
module slave_port #(
  parameter int ADDR_LEN  = 12,
  parameter int DATA_LEN  = 8,
  parameter int BURST_LEN = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_rx_address,
  input  logic                s_rx_burst,
  input  logic                s_rx_data,
  input  logic                s_write_en,
  input  logic                s_read_en,
  input  logic                s_master_valid,
  input  logic                s_master_ready,
  input  logic [5:0]          s_slave_delay,
  output logic                s_slave_ready,
  output logic                s_slave_valid,
  output logic                s_tx_data,
  output logic                s_split_en,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [DATA_LEN-1:0] mem_wdata,
  output logic                mem_we,
  output logic                mem_re,
  input  logic [DATA_LEN-1:0] mem_rdata
);
  localparam int CNT_W = $clog2((ADDR_LEN > DATA_LEN ? ADDR_LEN : DATA_LEN) + 1);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRITE, RDELAY, RFETCH, RDATA, DONE} state_t;
  state_t state, state_next;

  logic [ADDR_LEN-1:0]  addr_sr, addr_shift;
  logic [BURST_LEN-1:0] burst_sr, burst_shift, beat_cnt;
  logic [DATA_LEN-1:0]  data_sr, rd_word;
  logic [CNT_W-1:0]     bit_cnt;
  logic [5:0]           delay_cnt;
  logic                 is_write, rd_load;
  logic                 start, bit_last, beat_last, burst_take, delay_zero;

  assign start      = s_master_valid && (s_write_en ^ s_read_en);
  assign bit_last   = (bit_cnt == '0);
  assign beat_last  = (beat_cnt == '0);
  assign delay_zero = (s_slave_delay == 6'd0);
  // bit_cnt counts down from ADDR_LEN-2, so the current bit index is ADDR_LEN-1-bit_cnt
  assign burst_take = (state == IDLE) || ((CNT_W'(ADDR_LEN - 1) - bit_cnt) < CNT_W'(BURST_LEN));
  assign addr_shift  = {s_rx_address, addr_sr[ADDR_LEN-1:1]};
  assign burst_shift = burst_take ? {s_rx_burst, burst_sr[BURST_LEN-1:1]} : burst_sr;
  // the fetched word is forwarded straight from memory during the first RDATA cycle
  assign rd_word   = rd_load ? mem_rdata : data_sr;
  assign s_tx_data = (state == RDATA) ? rd_word[0] : 1'b0;
  assign mem_addr  = (mem_we || mem_re) ? addr_sr : '0;
  assign mem_wdata = mem_we ? data_sr : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    s_slave_ready = 1'b0;
    s_slave_valid = 1'b0;
    s_split_en    = 1'b0;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    case (state)
      IDLE: begin
        s_slave_ready = 1'b1;
        if (start) state_next = ADDR;
      end
      ADDR: begin
        s_slave_ready = 1'b1;
        if (s_master_valid && bit_last)
          state_next = is_write ? WDATA : (delay_zero ? RFETCH : RDELAY);
      end
      WDATA: begin
        s_slave_ready = 1'b1;
        if (s_master_valid && bit_last) state_next = WRITE;
      end
      WRITE: begin
        mem_we     = 1'b1;
        state_next = beat_last ? DONE : WDATA;
      end
      RDELAY: begin
        s_split_en = 1'b1;
        if (delay_cnt == 6'd0) state_next = RFETCH;
      end
      RFETCH: begin
        mem_re     = 1'b1;
        state_next = RDATA;
      end
      RDATA: begin
        s_slave_valid = 1'b1;
        if (s_master_ready && bit_last)
          state_next = beat_last ? DONE : (delay_zero ? RFETCH : RDELAY);
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_sr   <= '0;
      burst_sr  <= '0;
      beat_cnt  <= '0;
      data_sr   <= '0;
      bit_cnt   <= '0;
      delay_cnt <= '0;
      is_write  <= 1'b0;
      rd_load   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          addr_sr  <= addr_shift;
          burst_sr <= burst_shift;
          is_write <= s_write_en;
          bit_cnt  <= CNT_W'(ADDR_LEN - 2);
        end
        ADDR: if (s_master_valid) begin
          addr_sr  <= addr_shift;
          burst_sr <= burst_shift;
          if (bit_last) begin
            beat_cnt  <= (burst_shift == '0) ? '0 : burst_shift - 1'b1;
            bit_cnt   <= CNT_W'(DATA_LEN - 1);
            delay_cnt <= s_slave_delay - 6'd1;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        WDATA: if (s_master_valid) begin
          data_sr <= {s_rx_data, data_sr[DATA_LEN-1:1]};
          bit_cnt <= bit_cnt - 1'b1;
        end
        WRITE: begin
          bit_cnt <= CNT_W'(DATA_LEN - 1);
          if (!beat_last) begin
            beat_cnt <= beat_cnt - 1'b1;
            addr_sr  <= addr_sr + 1'b1;
          end
        end
        RDELAY: delay_cnt <= delay_cnt - 6'd1;
        RFETCH: begin
          rd_load <= 1'b1;
          bit_cnt <= CNT_W'(DATA_LEN - 1);
        end
        RDATA: begin
          rd_load <= 1'b0;
          if (s_master_ready) begin
            data_sr <= rd_word >> 1;
            bit_cnt <= bit_cnt - 1'b1;
            if (bit_last && !beat_last) begin
              beat_cnt  <= beat_cnt - 1'b1;
              addr_sr   <= addr_sr + 1'b1;
              delay_cnt <= s_slave_delay - 6'd1;
            end
          end else begin
            data_sr <= rd_word;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_slave_port.sv
// Randomized bench for slave_port: transactions are checked against expected
// memory accesses and serial read streams computed from address/burst/data.
`timescale 1ns/1ps
module tb_slave_port;
  localparam int AL = 12, DL = 8, BL = 12;

  logic          clk = 1'b0, reset;
  logic          s_rx_address, s_rx_burst, s_rx_data, s_write_en, s_read_en;
  logic          s_master_valid, s_master_ready;
  logic [5:0]    s_slave_delay;
  logic          s_slave_ready, s_slave_valid, s_tx_data, s_split_en;
  logic [AL-1:0] mem_addr;
  logic [DL-1:0] mem_wdata, mem_rdata = '0;
  logic          mem_we, mem_re;

  always #5 clk = ~clk;

  slave_port #(.ADDR_LEN(AL), .DATA_LEN(DL), .BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset), .s_rx_address(s_rx_address), .s_rx_burst(s_rx_burst),
    .s_rx_data(s_rx_data), .s_write_en(s_write_en), .s_read_en(s_read_en),
    .s_master_valid(s_master_valid), .s_master_ready(s_master_ready),
    .s_slave_delay(s_slave_delay), .s_slave_ready(s_slave_ready),
    .s_slave_valid(s_slave_valid), .s_tx_data(s_tx_data), .s_split_en(s_split_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata));

  int n_checks = 0, n_fail = 0, cyc = 0;
  int split_cycles, first_valid, inv_viol = 0;
  logic [7:0]  mem_model [4096];
  logic [19:0] got_wr [$];
  logic [11:0] got_re [$];
  bit          got_bits [$];
  logic [7:0]  wq [$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_re) mem_rdata <= mem_model[mem_addr];

  always @(negedge clk) begin
    if (mem_we) got_wr.push_back({mem_addr, mem_wdata});
    if (mem_re) got_re.push_back(mem_addr);
    if (s_slave_valid && s_master_ready) got_bits.push_back(s_tx_data);
    if (s_split_en) split_cycles++;
    if (s_slave_valid && first_valid < 0) first_valid = cyc;
    if ((mem_we && mem_re) || (s_slave_valid && s_split_en)) inv_viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick; @(posedge clk); #1; endtask

  task automatic check_idle(input string tag);
    check(tag, {6'b0, s_slave_ready, s_slave_valid, s_split_en, s_tx_data, mem_we, mem_re,
                mem_addr, mem_wdata}, {6'b0, 1'b1, 25'b0});
  endtask

  task automatic clear_mon;
    got_wr.delete(); got_re.delete(); got_bits.delete();
    split_cycles = 0; first_valid = -1;
  endtask

  function automatic int rnd_stall(input int pct);
    return ($urandom_range(99) < pct) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  task automatic send_bit(input logic a, input logic b, input logic d, input int stall_n);
    int g = 0;
    s_master_valid = 1'b0;
    repeat (stall_n) tick;
    while (!s_slave_ready && g < 50) begin tick; g++; end
    if (g >= 50) check("ready_timeout", 0, 1);
    s_rx_address = a; s_rx_burst = b; s_rx_data = d; s_master_valid = 1'b1;
    tick;
    s_master_valid = 1'b0;
  endtask

  task automatic send_hdr(input bit wr, input logic [11:0] addr, input logic [11:0] burst,
                          input int stall_pct, output int t_last);
    for (int i = 0; i < AL; i++) begin
      if (i == 0) begin s_write_en = wr; s_read_en = !wr; end
      else begin s_write_en = 1'($urandom); s_read_en = 1'($urandom); end
      send_bit(addr[i], burst[i], 1'b0, (i == 0) ? 0 : rnd_stall(stall_pct));
    end
    t_last = cyc;
    s_write_en = 1'b0; s_read_en = 1'b0;
  endtask

  task automatic run_write(input logic [11:0] addr, input logic [11:0] burst,
                           input int stall_pct, input int stall_bit);
    int beats, t;
    beats = (burst == 0) ? 1 : int'(burst);
    while (wq.size() < beats) wq.push_back(8'($urandom));
    clear_mon();
    send_hdr(1'b1, addr, burst, stall_pct, t);
    for (int k = 0; k < beats; k++)
      for (int i = 0; i < DL; i++)
        send_bit(1'b0, 1'b0, wq[k][i],
                 (k == 0 && i == stall_bit) ? 3 : rnd_stall(stall_pct));
    tick; tick;
    check("wr_count", got_wr.size(), beats);
    for (int k = 0; k < beats && k < got_wr.size(); k++) begin
      check("wr_addr", got_wr[k][19:8], (int'(addr) + k) % 4096);
      check("wr_data", got_wr[k][7:0], wq[k]);
    end
    check("wr_no_re", got_re.size(), 0);
    check("wr_idle_ready", s_slave_ready, 1);
    wq.delete();
  endtask

  task automatic run_read(input logic [11:0] addr, input logic [11:0] burst,
                          input int delay, input int stall_pct, input int rdy_pct);
    int beats, t, g;
    logic [7:0] w;
    beats = (burst == 0) ? 1 : int'(burst);
    clear_mon();
    s_slave_delay = 6'(delay);
    send_hdr(1'b0, addr, burst, stall_pct, t);
    g = 0;
    while (got_bits.size() < beats * DL && g < 3000) begin
      s_master_ready = (rdy_pct < 0) ? !s_master_ready : ($urandom_range(99) < rdy_pct);
      tick; g++;
    end
    if (g >= 3000) check("rd_timeout", got_bits.size(), beats * DL);
    s_master_ready = 1'b0;
    tick;
    check("rd_first_valid", first_valid, t + delay + 1);
    check("rd_split_cycles", split_cycles, (delay == 0) ? 0 : delay * beats);
    check("rd_count", got_re.size(), beats);
    for (int k = 0; k < beats && k < got_re.size(); k++)
      check("rd_addr", got_re[k], (int'(addr) + k) % 4096);
    for (int k = 0; k < beats && (k + 1) * DL <= got_bits.size(); k++) begin
      for (int i = 0; i < DL; i++) w[i] = got_bits[k * DL + i];
      check("rd_data", w, mem_model[(int'(addr) + k) % 4096]);
    end
    check("rd_no_we", got_wr.size(), 0);
    check("rd_idle_ready", s_slave_ready, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    reset = 1'b1;
    s_rx_address = 0; s_rx_burst = 0; s_rx_data = 0; s_write_en = 0; s_read_en = 0;
    s_master_valid = 0; s_master_ready = 0; s_slave_delay = 0;
    for (int i = 0; i < 4096; i++) mem_model[i] = 8'($urandom);
    repeat (3) tick;
    check_idle("reset_outputs");
    reset = 1'b0;
    tick;

    wq.push_back(8'hA5);
    run_write(12'h005, 12'd0, 0, -1);

    mem_model[12'h010] = 8'h11; mem_model[12'h011] = 8'h22; mem_model[12'h012] = 8'h33;
    run_read(12'h010, 12'd3, 0, 0, 100);

    run_write(12'hFFF, 12'd2, 0, 3);

    run_read(12'h040, 12'd0, 5, 0, -1);
    run_read(12'hFFE, 12'd3, 2, 20, 50);

    clear_mon();
    s_write_en = 1'b1; s_read_en = 1'b1; s_master_valid = 1'b1;
    repeat (3) begin tick; check("both_en_idle", s_slave_ready, 1); end
    s_write_en = 1'b0; s_read_en = 1'b0;
    repeat (2) begin tick; check("no_en_idle", s_slave_ready, 1); end
    s_master_valid = 1'b0;
    check("ignored_no_strobes", got_wr.size() + got_re.size(), 0);

    clear_mon();
    send_hdr(1'b1, 12'h123, 12'd0, 0, t);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0, 1'($urandom), 0);
    s_rx_data = 1'b1; s_master_valid = 1'b1;
    #2 reset = 1'b1;
    #1 check_idle("mid_reset_outputs");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; s_master_valid = 1'b0;
    tick;
    check("mid_reset_no_we", got_wr.size(), 0);
    run_write(12'h123, 12'd1, 0, -1);

    repeat (24) begin
      logic [11:0] a;
      a = ($urandom_range(3) == 0) ? 12'hFFD + 12'($urandom_range(0, 2)) : 12'($urandom);
      if ($urandom_range(1) == 1)
        run_write(a, 12'($urandom_range(0, 4)), 20, -1);
      else
        run_read(a, 12'($urandom_range(0, 4)), int'($urandom_range(0, 7)), 20, 60);
    end

    check("strobe_exclusive", inv_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
